// File: rtl/martin_median_filter.sv
// 8-tap median / high-pass filter: addressed sample registers, registered median, output mode mux.
// Build option FILTER_SAT_EN: mode 01 clamps negative differences to zero instead of wrapping.
module martin_median_filter #(
    parameter int DATA_W     = 8,
    parameter int NUM_TAPS   = 8,
    parameter int MEDIAN_IDX = 4
) (
    input  logic              clk_pad,
    input  logic              rst_pad,
    input  logic [DATA_W-1:0] data_in_pad,
    input  logic [2:0]        reg_addr_pad,
    input  logic              wr_enable_pad,
    input  logic [1:0]        out_select_pad,
    output logic [DATA_W-1:0] data_out_pad
);

    logic [DATA_W-1:0] r_taps [NUM_TAPS];
    logic [DATA_W-1:0] r_median;
    logic [DATA_W-1:0] w_median;
    logic [DATA_W-1:0] w_data_out;

    always_ff @(posedge clk_pad) begin
        if (rst_pad) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_taps[i] <= '0;
            end
            r_median <= '0;
        end else begin
            if (wr_enable_pad) begin
                r_taps[reg_addr_pad] <= data_in_pad;
            end
            r_median <= w_median;
        end
    end

    // Odd-even transposition network: NUM_TAPS compare/swap stages sort ascending.
    always_comb begin
        logic [DATA_W-1:0] v [NUM_TAPS];
        logic [DATA_W-1:0] t;
        w_median = '0;
        t        = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            v[i] = r_taps[i];
        end
        for (int s = 0; s < NUM_TAPS; s++) begin
            for (int i = s % 2; i < NUM_TAPS - 1; i += 2) begin
                if (v[i] > v[i+1]) begin
                    t      = v[i];
                    v[i]   = v[i+1];
                    v[i+1] = t;
                end
            end
        end
        w_median = v[MEDIAN_IDX];
    end

    always_comb begin
        w_data_out = '0;
        case (out_select_pad)
            2'b00: w_data_out = r_median;
`ifdef FILTER_SAT_EN
            2'b01: w_data_out = (data_in_pad < r_median) ? '0 : (data_in_pad - r_median);
`else
            2'b01: w_data_out = data_in_pad - r_median;
`endif
            2'b10: w_data_out = data_in_pad;
            default: w_data_out = '0;
        endcase
    end

    assign data_out_pad = w_data_out;

endmodule

// File: tb/tb_martin_median_filter.sv
// Directed bench for martin_median_filter: transparent, reset, median, latency, filter and reset-vs-write.
module tb_martin_median_filter;

    logic       clk_pad = 1'b0;
    logic       rst_pad;
    logic [7:0] data_in_pad;
    logic [2:0] reg_addr_pad;
    logic       wr_enable_pad;
    logic [1:0] out_select_pad;
    logic [7:0] data_out_pad;

    int checks = 0;
    int errors = 0;

    martin_median_filter dut (
        .clk_pad        (clk_pad),
        .rst_pad        (rst_pad),
        .data_in_pad    (data_in_pad),
        .reg_addr_pad   (reg_addr_pad),
        .wr_enable_pad  (wr_enable_pad),
        .out_select_pad (out_select_pad),
        .data_out_pad   (data_out_pad)
    );

    always #5 clk_pad = ~clk_pad;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
    task automatic tick();
        @(posedge clk_pad);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        #1;
        checks++;
        assert (data_out_pad === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, data_out_pad, exp);
        end
    endtask

    task automatic write_tap(input logic [2:0] addr, input logic [7:0] data);
        wr_enable_pad = 1'b1;
        reg_addr_pad  = addr;
        data_in_pad   = data;
        tick();
        wr_enable_pad = 1'b0;
    endtask

    initial begin
        logic [7:0] rnd;
        logic [7:0] set_a [8];
        set_a = '{8'd10, 8'd80, 8'd30, 8'd70, 8'd50, 8'd20, 8'd60, 8'd40};

        rst_pad        = 1'b1;
        data_in_pad    = 8'h00;
        reg_addr_pad   = 3'd0;
        wr_enable_pad  = 1'b0;
        out_select_pad = 2'b10;
        tick();
        data_in_pad = 8'hC3;
        check("transparent_in_reset", 8'hC3);
        tick();
        rst_pad        = 1'b0;
        out_select_pad = 2'b00;
        check("reset_median", 8'h00);
        out_select_pad = 2'b11;
        data_in_pad    = 8'hFF;
        check("reset_mode11", 8'h00);

        out_select_pad = 2'b10;
        data_in_pad = 8'h00; check("transparent_00", 8'h00);
        data_in_pad = 8'h5A; check("transparent_5a", 8'h5A);
        data_in_pad = 8'hFF; check("transparent_ff", 8'hFF);
        for (int i = 0; i < 4; i++) begin
            rnd = 8'($urandom_range(0, 255));
            data_in_pad = rnd;
            check("transparent_rand", rnd);
        end

        for (int i = 0; i < 8; i++) begin
            write_tap(3'(i), set_a[i]);
        end
        tick();
        out_select_pad = 2'b00;
        check("median_set_a", 8'd50);

        out_select_pad = 2'b01;
        data_in_pad = 8'h80; check("filter_80", 8'h4E);
`ifdef FILTER_SAT_EN
        data_in_pad = 8'd10; check("filter_10_sat", 8'h00);
`else
        data_in_pad = 8'd10; check("filter_10_wrap", 8'hD8);
`endif
        data_in_pad = 8'd50; check("filter_equal", 8'h00);
        out_select_pad = 2'b00;
        check("median_after_modes", 8'd50);

        rst_pad = 1'b1;
        tick();
        rst_pad = 1'b0;
        out_select_pad = 2'b00;
        tick();
        check("median_after_reset", 8'h00);

        for (int i = 0; i < 8; i++) begin
            write_tap(3'(i), 8'h7F);
        end
        tick();
        check("median_all_7f", 8'h7F);

        // Tap 7 still holds 7F at the final write edge, so the old median persists one cycle.
        for (int i = 0; i < 4; i++) write_tap(3'(i), 8'h00);
        for (int i = 4; i < 7; i++) write_tap(3'(i), 8'hFF);
        write_tap(3'd7, 8'hFF);
        check("latency_old", 8'h7F);
        tick();
        check("latency_new", 8'hFF);

        rst_pad       = 1'b1;
        wr_enable_pad = 1'b1;
        reg_addr_pad  = 3'd7;
        data_in_pad   = 8'hAA;
        tick();
        rst_pad       = 1'b0;
        wr_enable_pad = 1'b0;
        tick();
        check("rst_wr_median_zero", 8'h00);
        for (int i = 0; i < 3; i++) write_tap(3'(i), 8'hAA);
        tick();
        check("rst_wr_tap7_cleared", 8'h00);
        out_select_pad = 2'b11;
        data_in_pad    = 8'h5A;
        check("mode11_zero", 8'h00);
        write_tap(3'd7, 8'hAA);
        tick();
        out_select_pad = 2'b00;
        check("median_four_aa", 8'hAA);
        out_select_pad = 2'b11;
        check("mode11_zero_again", 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
